ssd_scan_decoder: RTL and testbench

Passive monitor on the 8-digit multiplexed seven-segment bus (An, SSD_CATHODES) driven by the game's timer display. It samples each digit after its anode has been stable for a settle period and decodes the segment pattern back to BCD. It reports a complete frame and converts the current and best times to binary tenths of a second. It is used by the score logger and by self-checking benches.

---
 rtl/ssd_scan_decoder.sv | 180 ++++++++++++++++++
 tb/tb_ssd_scan_decoder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder
//
// Passive monitor for the 8-digit multiplexed seven-segment bus of the game
// timer. It waits for each digit's anode to dwell long enough to be trusted,
// samples the cathodes once, and decodes the segment pattern back to BCD.
// Once all eight digits have been captured, it reports a frame. It also
// converts the current time (digits 3..0) and the best time (digits 7..4)
// to binary tenths of a second.
//
// Ports:
//   clk           system clock (100 MHz)
//   rst           asynchronous reset, active low
//   An            anodes, active-low one-cold; An[7-i] low selects digit i
//   SSD_CATHODES  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active low
//   clear         synchronous clear of all captured state
//   digits        BCD nibbles, digits[4i+3:4i] = digit i
//   dp_mask       decimal point lit on digit i at its last sample
//   digit_valid   sticky, digit i captured since reset/clear
//   frame_done    one-cycle pulse after all 8 digits captured in a frame
//   cur_tenths    binary value of digits 3..0, updated with frame_done
//   best_tenths   binary value of digits 7..4, updated with frame_done
//   seg_err       one-cycle pulse, sampled pattern is not a decimal digit
//   err_digit     digit index of the most recent seg_err
//   anode_err     high every cycle the registered anodes are illegal
//
// SETTLE_CYCLES: the number of consecutive cycles a legal anode pattern must
// be stable before the cathodes are sampled. The legal range is 2..65535.

module ssd_scan_decoder #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  An,
  input  logic [7:0]  SSD_CATHODES,
  input  logic        clear,
  output logic [31:0] digits,
  output logic [7:0]  dp_mask,
  output logic [7:0]  digit_valid,
  output logic        frame_done,
  output logic [13:0] cur_tenths,
  output logic [13:0] best_tenths,
  output logic        seg_err,
  output logic [2:0]  err_digit,
  output logic        anode_err
);

  localparam logic [15:0] SAMPLE_AT = 16'(SETTLE_CYCLES - 1);

  logic [7:0]  An_r;
  logic [7:0]  C_r;
  logic [15:0] settle_cnt;
  logic [7:0]  seen;

  logic        an_legal;
  logic        an_blank;
  logic [2:0]  an_idx;
  logic        an_changed;
  logic        sample_now;
  logic [3:0]  dec_val;
  logic        dec_ok;

  // Input stage. An_r resets to all-high, which means no digit is selected.
  // This keeps anode_err quiet during reset. It also guarantees that the first
  // latched legal pattern looks like a change, so the full settle count is
  // needed after reset even if the display kept driving the same digit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      An_r <= 8'hFF;
      C_r  <= 8'h00;
    end else begin
      An_r <= An;
      C_r  <= SSD_CATHODES;
    end
  end

  // Classify the registered anodes. Exactly one low bit selects a digit, and
  // all high is a blanking gap. Every other pattern is a bus fault.
  always_comb begin
    an_legal = 1'b0;
    an_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (An_r == ~(8'd1 << i)) begin
        an_legal = 1'b1;
        an_idx   = 3'(7 - i);
      end
    end
  end

  assign an_blank   = (An_r == 8'hFF);
  assign anode_err  = !an_legal && !an_blank;
  assign an_changed = (An != An_r);

  // The dwell counter restarts whenever the latched anodes are about to take
  // a new value, whenever they are not a legal selection, and on clear.
  // It saturates instead of wrapping. This way a very long dwell can never
  // pass SAMPLE_AT a second time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_cnt <= 16'd0;
    end else if (clear || an_changed || !an_legal) begin
      settle_cnt <= 16'd0;
    end else if (settle_cnt != 16'hFFFF) begin
      settle_cnt <= settle_cnt + 16'd1;
    end
  end

  assign sample_now = an_legal && (settle_cnt == SAMPLE_AT) && !clear;

  // Segment decode of {Ca..Cg}. Each bit is 0 when its segment is lit.
  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'd0;
    case (C_r[7:1])
      7'b0000001: dec_val = 4'd0;
      7'b1001111: dec_val = 4'd1;
      7'b0010010: dec_val = 4'd2;
      7'b0000110: dec_val = 4'd3;
      7'b1001100: dec_val = 4'd4;
      7'b0100100: dec_val = 4'd5;
      7'b0100000: dec_val = 4'd6;
      7'b0001111: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0000100: dec_val = 4'd9;
      default:    dec_ok  = 1'b0;
    endcase
  end

  function automatic logic [13:0] bcd_to_bin(input logic [15:0] bcd);
    return 14'(bcd[15:12]) * 14'd1000 + 14'(bcd[11:8]) * 14'd100
         + 14'(bcd[7:4]) * 14'd10 + 14'(bcd[3:0]);
  endfunction

  // Capture state. Clear wins over any sample or frame completion in the same
  // cycle. A frame completes one cycle after the seen mask fills. The binary
  // times are then computed from the nibbles of that completed frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digits      <= 32'd0;
      dp_mask     <= 8'd0;
      digit_valid <= 8'd0;
      seen        <= 8'd0;
      frame_done  <= 1'b0;
      cur_tenths  <= 14'd0;
      best_tenths <= 14'd0;
      seg_err     <= 1'b0;
      err_digit   <= 3'd0;
    end else begin
      frame_done <= 1'b0;
      seg_err    <= 1'b0;
      if (clear) begin
        digits      <= 32'd0;
        dp_mask     <= 8'd0;
        digit_valid <= 8'd0;
        seen        <= 8'd0;
        cur_tenths  <= 14'd0;
        best_tenths <= 14'd0;
      end else begin
        if (seen == 8'hFF) begin
          frame_done  <= 1'b1;
          seen        <= 8'd0;
          cur_tenths  <= bcd_to_bin(digits[15:0]);
          best_tenths <= bcd_to_bin(digits[31:16]);
        end
        if (sample_now) begin
          if (dec_ok) begin
            digits[{an_idx, 2'b00} +: 4] <= dec_val;
            dp_mask[an_idx]              <= ~C_r[0];
            digit_valid[an_idx]          <= 1'b1;
            seen[an_idx]                 <= 1'b1;
          end else begin
            seg_err   <= 1'b1;
            err_digit <= an_idx;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// tb_ssd_scan_decoder
//
// Self-checking bench for ssd_scan_decoder. It drives directed scans and
// random dwells, and compares every output each cycle against a behavioural
// model. The model reasons in terms of dwells: a digit is sampled exactly
// SETTLE clock edges after its anode pattern was latched (or after a clear).

module tb_ssd_scan_decoder;

  localparam int SETTLE = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  An = 8'hFF;
  logic [7:0]  SSD_CATHODES = 8'hFF;
  logic        clear = 1'b0;
  logic [31:0] digits;
  logic [7:0]  dp_mask;
  logic [7:0]  digit_valid;
  logic        frame_done;
  logic [13:0] cur_tenths;
  logic [13:0] best_tenths;
  logic        seg_err;
  logic [2:0]  err_digit;
  logic        anode_err;

  always #5 clk = ~clk;

  ssd_scan_decoder #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst), .An(An), .SSD_CATHODES(SSD_CATHODES), .clear(clear),
    .digits(digits), .dp_mask(dp_mask), .digit_valid(digit_valid),
    .frame_done(frame_done), .cur_tenths(cur_tenths), .best_tenths(best_tenths),
    .seg_err(seg_err), .err_digit(err_digit), .anode_err(anode_err)
  );

  int checks = 0;
  int errors = 0;
  int fdCount = 0;
  int aeCount = 0;

  logic [6:0] segTable [10];

  // Reference model state
  logic [7:0] mAnR, mCr;
  int  edgeNo, dwellStart;
  int  mDigit [8];
  bit  mDp [8], mValid [8], mSeen [8];
  bit  mFrameDone, mSegErr;
  int  mCur, mBest, mErrDigit;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int zeroCount(input logic [7:0] a);
    int n = 0;
    for (int i = 0; i < 8; i++) if (!a[i]) n++;
    return n;
  endfunction

  function automatic int lowPos(input logic [7:0] a);
    for (int i = 0; i < 8; i++) if (!a[i]) return i;
    return 0;
  endfunction

  function automatic int decodeSeg(input logic [6:0] p);
    for (int d = 0; d < 10; d++) if (segTable[d] == p) return d;
    return -1;
  endfunction

  function automatic logic [7:0] anFor(input int i);
    logic [7:0] a = 8'h80;
    return ~(a >> i);
  endfunction

  function automatic logic [7:0] cathFor(input int d, input bit dpLit);
    return {segTable[d], ~dpLit};
  endfunction

  task automatic modelReset();
    mAnR = 8'hFF; mCr = 8'h00;
    dwellStart = -100000;
    mFrameDone = 0; mSegErr = 0; mCur = 0; mBest = 0; mErrDigit = 0;
    for (int i = 0; i < 8; i++) begin
      mDigit[i] = 0; mDp[i] = 0; mValid[i] = 0; mSeen[i] = 0;
    end
  endtask

  // One clock edge of the model, using the inputs that were present before the edge.
  task automatic modelEdge(input logic [7:0] an, input logic [7:0] cath, input bit clr);
    int e, idx, d;
    bit full, legal;
    e = edgeNo + 1;
    full = 1;
    for (int i = 0; i < 8; i++) if (!mSeen[i]) full = 0;
    legal = (zeroCount(mAnR) == 1);
    idx = 7 - lowPos(mAnR);
    mFrameDone = 0;
    mSegErr = 0;
    if (clr) begin
      for (int i = 0; i < 8; i++) begin
        mDigit[i] = 0; mDp[i] = 0; mValid[i] = 0; mSeen[i] = 0;
      end
      mCur = 0; mBest = 0;
      dwellStart = e;
    end else begin
      if (full) begin
        mFrameDone = 1;
        mCur  = mDigit[3] * 1000 + mDigit[2] * 100 + mDigit[1] * 10 + mDigit[0];
        mBest = mDigit[7] * 1000 + mDigit[6] * 100 + mDigit[5] * 10 + mDigit[4];
        for (int i = 0; i < 8; i++) mSeen[i] = 0;
      end
      if (legal && e == dwellStart + SETTLE) begin
        d = decodeSeg(mCr[7:1]);
        if (d >= 0) begin
          mDigit[idx] = d; mDp[idx] = !mCr[0]; mValid[idx] = 1; mSeen[idx] = 1;
        end else begin
          mSegErr = 1; mErrDigit = idx;
        end
      end
    end
    if (an != mAnR) dwellStart = e;
    mAnR = an;
    mCr = cath;
    edgeNo = e;
  endtask

  task automatic compareAll();
    logic [31:0] expDigits;
    logic [7:0] expDp, expValid;
    for (int i = 0; i < 8; i++) begin
      expDigits[4*i +: 4] = 4'(mDigit[i]);
      expDp[i] = mDp[i];
      expValid[i] = mValid[i];
    end
    checkOutput("digits", digits, expDigits);
    checkOutput("dp_mask", {24'd0, dp_mask}, {24'd0, expDp});
    checkOutput("digit_valid", {24'd0, digit_valid}, {24'd0, expValid});
    checkOutput("frame_done", {31'd0, frame_done}, {31'd0, mFrameDone});
    checkOutput("cur_tenths", {18'd0, cur_tenths}, 32'(mCur));
    checkOutput("best_tenths", {18'd0, best_tenths}, 32'(mBest));
    checkOutput("seg_err", {31'd0, seg_err}, {31'd0, mSegErr});
    checkOutput("err_digit", {29'd0, err_digit}, 32'(mErrDigit));
    checkOutput("anode_err", {31'd0, anode_err}, {31'd0, zeroCount(mAnR) > 1});
    fdCount += int'(frame_done);
    aeCount += int'(anode_err);
  endtask

  task automatic applyStimulus(input logic [7:0] an, input logic [7:0] cath,
                               input bit clr, input int n);
    for (int k = 0; k < n; k++) begin
      An = an; SSD_CATHODES = cath; clear = clr;
      @(posedge clk);
      modelEdge(an, cath, clr);
      @(negedge clk);
      compareAll();
    end
  endtask

  task automatic resetPulse(input int n);
    rst = 1'b0;
    modelReset();
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      compareAll();
    end
    rst = 1'b1;
  endtask

  task automatic scanFrame(input int v[8], input int dpMaskIn, input int dwell);
    for (int i = 0; i < 8; i++)
      applyStimulus(anFor(i), cathFor(v[i], dpMaskIn[i]), 1'b0, dwell);
  endtask

  initial begin
    int frameVals [8];
    int fd0, ae0, upd, first;
    logic [7:0] an, cath;
    segTable = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    edgeNo = 0;
    modelReset();
    @(negedge clk);
    resetPulse(2);

    // Two identical frames: 12.3 current, 45.6 best, decimal points on digits 1 and 5
    frameVals = '{3, 2, 1, 0, 6, 5, 4, 0};
    fd0 = fdCount;
    scanFrame(frameVals, 8'h22, 100);
    scanFrame(frameVals, 8'h22, 100);
    checkOutput("frame_digits", digits, 32'h0456_0123);
    checkOutput("frame_dp", {24'd0, dp_mask}, 32'h22);
    checkOutput("frame_valid", {24'd0, digit_valid}, 32'hFF);
    checkOutput("frame_cur", {18'd0, cur_tenths}, 32'd123);
    checkOutput("frame_best", {18'd0, best_tenths}, 32'd456);
    checkOutput("frame_done_pulses", 32'(fdCount - fd0), 32'd2);

    // A short dwell must not sample. A 17-cycle dwell samples on the 17th edge.
    applyStimulus(anFor(0), cathFor(7, 0), 1'b0, 10);
    applyStimulus(anFor(1), cathFor(2, 1), 1'b0, 5);
    checkOutput("hold10_no_update", {28'd0, digits[3:0]}, 32'd3);
    upd = -1;
    for (int k = 1; k <= 17; k++) begin
      applyStimulus(anFor(0), cathFor(7, 0), 1'b0, 1);
      if (digits[3:0] == 4'd7 && upd < 0) upd = k;
    end
    checkOutput("hold17_update_edge", 32'(upd), 32'd17);
    applyStimulus(anFor(0), cathFor(7, 0), 1'b0, 40);

    // Digit 2 shows "A": a segment error, and no frame completes
    fd0 = fdCount;
    frameVals = '{3, 2, 1, 0, 6, 5, 4, 0};
    for (int i = 0; i < 8; i++) begin
      cath = (i == 2) ? 8'b0001_0000 : cathFor(frameVals[i], 0);
      applyStimulus(anFor(i), cath, 1'b0, 40);
      if (i == 2) checkOutput("err_digit_A", {29'd0, err_digit}, 32'd2);
    end
    checkOutput("no_frame_on_seg_err", 32'(fdCount - fd0), 32'd0);

    // Illegal anodes held for 50 cycles
    ae0 = aeCount;
    applyStimulus(8'b1111_0011, cathFor(8, 0), 1'b0, 50);
    checkOutput("anode_err_cycles", 32'(aeCount - ae0), 32'd50);
    applyStimulus(8'hFF, cathFor(8, 0), 1'b0, 5);

    // Reset in the middle of a dwell, with the anodes held
    applyStimulus(anFor(3), cathFor(9, 0), 1'b0, 11);
    resetPulse(3);
    first = -1;
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(anFor(3), cathFor(9, 0), 1'b0, 1);
      if (digit_valid[3] && first < 0) first = k;
    end
    checkOutput("rst_settle_cycles", 32'(first - 1), 32'(SETTLE));

    // Clear in the sample cycle of digit 4
    applyStimulus(anFor(4), cathFor(8, 0), 1'b0, 16);
    applyStimulus(anFor(4), cathFor(8, 0), 1'b1, 1);
    applyStimulus(anFor(4), cathFor(8, 0), 1'b0, 3);
    checkOutput("clear_digits", digits, 32'd0);
    checkOutput("clear_valid", {24'd0, digit_valid}, 32'd0);
    applyStimulus(anFor(5), cathFor(1, 1), 1'b0, 20);
    checkOutput("after_clear_d5", digits, 32'h0010_0000);
    checkOutput("after_clear_valid", {24'd0, digit_valid}, 32'h20);

    // Random dwells: legal digits (mostly valid patterns), blanks, faults, clears
    for (int s = 0; s < 300; s++) begin
      int kind, a, b;
      kind = $urandom_range(0, 19);
      cath = ($urandom_range(0, 9) < 8) ? cathFor($urandom_range(0, 9), 1'($urandom_range(0, 1)))
                                        : 8'($urandom_range(0, 255));
      if (kind == 0) begin
        a = $urandom_range(0, 7);
        b = (a + 1 + $urandom_range(0, 6)) % 8;
        an = 8'hFF & ~(8'd1 << a) & ~(8'd1 << b);
        applyStimulus(an, cath, 1'b0, $urandom_range(1, 40));
      end else if (kind == 1) begin
        applyStimulus(8'hFF, cath, 1'b0, $urandom_range(1, 40));
      end else if (kind == 2) begin
        applyStimulus(An, SSD_CATHODES, 1'b1, 1);
      end else begin
        applyStimulus(anFor($urandom_range(0, 7)), cath, 1'b0, $urandom_range(1, 40));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
